// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared state encoding and default frame shape for uart_tx_arbiter
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int unsigned c_OVERSAMPLE = 16;
  localparam int unsigned c_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer : bit timing and LSB-first shift of one UART frame
// Rev 1.0
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = c_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = c_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 tick,
  output logic                 tx,
  output logic                 bit_done,
  output logic                 done
);

  localparam int unsigned CW    = ($clog2(OVERSAMPLE) < 4) ? 4 : $clog2(OVERSAMPLE);
  localparam int unsigned NBITS = DATA_BITS + 2;
  localparam int unsigned IW    = $clog2(NBITS);

  localparam logic [CW-1:0] c_CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] c_IDX_STOP  = IW'(NBITS - 1);
  localparam logic [IW-1:0] c_IDX_LASTD = IW'(DATA_BITS);

  logic [DATA_BITS-1:0] shift_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 active_q;
  logic                 tx_q;
  logic                 w_bit_end;

  assign w_bit_end = active_q && tick && (tick_cnt_q == c_CNT_LAST);
  assign bit_done  = w_bit_end;
  assign done      = w_bit_end && (bit_idx_q == c_IDX_STOP);
  assign tx        = tx_q;

  // bit_idx_q: 0 = start bit, 1..DATA_BITS = payload, DATA_BITS+1 = stop bit.
  // start wins over tick, so a tick on the load cycle never counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      active_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (start) begin
      shift_q    <= data;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      active_q   <= 1'b1;
      tx_q       <= 1'b0;
    end else if (active_q && tick) begin
      if (tick_cnt_q == c_CNT_LAST) begin
        tick_cnt_q <= '0;
        if (bit_idx_q < c_IDX_LASTD) begin
          tx_q    <= shift_q[0];
          shift_q <= shift_q >> 1;
        end else begin
          tx_q <= 1'b1;
        end
        if (bit_idx_q == c_IDX_STOP) begin
          active_q  <= 1'b0;
          bit_idx_q <= '0;
        end else begin
          bit_idx_q <= bit_idx_q + 1'b1;
        end
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin arbitration of two byte requesters onto one UART TX line
// Rev 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = c_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = c_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [BW-1:0]        data_cnt_q;
  logic                 prio_q;
  logic                 grant_id_q;
  logic                 req0_ready_q;
  logic                 req1_ready_q;
  logic                 w_accept;
  logic                 w_pick;
  logic [DATA_BITS-1:0] w_data;
  logic                 w_bit_done;
  logic                 w_frame_done;

  // A lone requester wins outright; on a tie prio_q names the favoured one.
  assign w_accept = (state_q == IDLE) && (req0_valid || req1_valid);
  assign w_pick   = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign w_data   = w_pick ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_cnt_q   <= '0;
      prio_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
    end else begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            state_q      <= START;
            grant_id_q   <= w_pick;
            prio_q       <= ~w_pick;
            req0_ready_q <= ~w_pick;
            req1_ready_q <= w_pick;
          end
        end
        START: begin
          if (w_bit_done) begin
            state_q    <= DATA;
            data_cnt_q <= '0;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            if (data_cnt_q == c_LAST_BIT) begin
              state_q <= STOP;
            end else begin
              data_cnt_q <= data_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_frame_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != IDLE);

  uart_tx_serializer #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .start    (w_accept),
    .data     (w_data),
    .tick     (tick),
    .tx       (tx),
    .bit_done (w_bit_done),
    .done     (w_frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_arbiter : directed frame vectors plus reset / timing corner cases
// Rev 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 781_250;
  localparam int unsigned TICK_DIV   = CLK_HZ / (BAUD * OVERSAMPLE);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       req0_valid = 1'b0;
  logic       req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx;
  logic       busy;
  logic       grant_id;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned tdiv = 0;

  typedef struct {
    bit         do_rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       exp_gid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  uart_tx_arbiter #(
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial forever #10 clk = ~clk;

  // Baud-rate generator: one-clk tick every TICK_DIV clocks, updated just after posedge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tdiv == TICK_DIV - 1) begin
        tdiv = 0;
        tick = 1'b1;
      end else begin
        tdiv = tdiv + 1;
        tick = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input int unsigned got, input int unsigned want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check({tx, busy, req0_ready, req1_ready, grant_id} === 5'b10000, "reset_state",
          32'({tx, busy, req0_ready, req1_ready, grant_id}), 32'h10);
    rst = 1'b1;
  endtask

  // Entered at a negedge; returns at the negedge right after the stop bit ends.
  task automatic run_frame(input logic exp_gid, input logic [7:0] exp_data,
                           input bit release_after, input string tag);
    logic [9:0]  exp_bits;
    int unsigned n;
    int unsigned guard;
    int unsigned extra_ready;
    bit          ok;
    logic        bad_val;
    exp_bits = {1'b1, exp_data, 1'b0};
    guard = 0;
    while (busy !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(busy === 1'b1, {tag, "_accept"}, 32'(busy), 32'd1);
    if (busy !== 1'b1) return;
    check(grant_id === exp_gid, {tag, "_grant_id"}, 32'(grant_id), 32'(exp_gid));
    check({req1_ready, req0_ready} === (exp_gid ? 2'b10 : 2'b01), {tag, "_ready_pulse"},
          32'({req1_ready, req0_ready}), exp_gid ? 32'h2 : 32'h1);
    if (release_after) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = 8'hFF;
      req1_data  = 8'hFF;
    end
    extra_ready = 0;
    for (int b = 0; b < 10; b++) begin
      ok = 1'b1;
      bad_val = exp_bits[b];
      n = 0;
      guard = 0;
      while (n < OVERSAMPLE && guard < 200) begin
        if (tx !== exp_bits[b] || busy !== 1'b1) begin
          ok = 1'b0;
          bad_val = tx;
        end
        if (!(b == 0 && guard == 0) && (req0_ready || req1_ready)) extra_ready++;
        if (tick) n++;
        @(negedge clk);
        guard++;
      end
      check(ok && n == OVERSAMPLE, $sformatf("%s_bit%0d", tag, b), 32'(bad_val), 32'(exp_bits[b]));
    end
    check({busy, tx} === 2'b01, {tag, "_idle_after_stop"}, 32'({busy, tx}), 32'h1);
    check(extra_ready == 0, {tag, "_single_ready"}, extra_ready, 0);
  endtask

  int unsigned n;
  int unsigned guard;
  bit          ok;

  initial begin
    //            rst   v0    d0     v1    d1     gid   payload
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 8'hC3};
    vecs[3] = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1, 8'hC3};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 8'h5A};
    vecs[6] = '{1'b0, 1'b1, 8'h96, 1'b1, 8'h69, 1'b0, 8'h96};

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) do_reset();
      req0_valid = vecs[i].v0;
      req0_data  = vecs[i].d0;
      req1_valid = vecs[i].v1;
      req1_data  = vecs[i].d1;
      run_frame(vecs[i].exp_gid, vecs[i].exp_data, 1'b0, $sformatf("vec%0d", i));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Payload changes right after acceptance must not reach the line.
    do_reset();
    req1_valid = 1'b1;
    req1_data  = 8'h0F;
    run_frame(1'b1, 8'h0F, 1'b1, "datachg");

    // Acceptance on a tick clock: START must still last 16 later ticks.
    do_reset();
    guard = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (tick !== 1'b1 && guard < 20);
    req1_valid = 1'b1;
    req1_data  = 8'h81;
    @(negedge clk);
    check(tick === 1'b1 && busy === 1'b0, "tickacc_pre", 32'({tick, busy}), 32'h2);
    @(negedge clk);
    check(busy === 1'b1, "tickacc_on_tick", 32'(busy), 32'd1);
    run_frame(1'b1, 8'h81, 1'b1, "tickacc");

    // Reset during DATA bit 3 of 8'hA5 (bit value 0).
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 8'hA5;
    guard = 0;
    while (busy !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(busy === 1'b1, "midrst_accept", 32'(busy), 32'd1);
    req0_valid = 1'b0;
    n = 0;
    guard = 0;
    while (n < 4 * OVERSAMPLE + 6 && guard < 2000) begin
      if (tick) n++;
      @(negedge clk);
      guard++;
    end
    check(tx === 1'b0 && busy === 1'b1, "midrst_in_bit3", 32'({busy, tx}), 32'h2);
    #3;
    rst = 1'b0;
    #1;
    check({tx, busy, req0_ready, req1_ready} === 4'b1000, "midrst_async",
          32'({tx, busy, req0_ready, req1_ready}), 32'h8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check(ok, "midrst_no_resume", 32'({busy, tx}), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
